// File: rtl/axi_rs_chain.sv
// axi_rs_chain: cascade of valid/ready register slices.
//   MODE 0 = combinational pass-through, 1 = forward (registered valid/data),
//   2 = backward (registered ready via skid), 3 = full (forward then backward).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   m_data/m_valid/m_ready : upstream beat interface (m_ready is an output)
//   s_data/s_valid/s_ready : downstream beat interface (s_ready is an input)
//   occ                 : number of beats currently held in slice registers
//   idle                : occ == 0 and no upstream beat offered

// One slice stage; MODE selects which halves exist (1..3 only).
module axi_rs_stage #(
  parameter int DW   = 64,
  parameter int MODE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    occ
);
  localparam bit HAS_FWD = (MODE == 1) || (MODE == 3);
  localparam bit HAS_BWD = (MODE == 2) || (MODE == 3);

  // Link between the forward half and the backward half.
  logic [DW-1:0] mid_data;
  logic          mid_valid, mid_ready;
  logic          f_occ, b_occ;

  if (HAS_FWD) begin : g_fwd
    logic          fv;
    logic [DW-1:0] fd;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fv <= 1'b0;
        fd <= '0;
      end else if (in_ready) begin
        fv <= in_valid;
        if (in_valid) fd <= in_data;
      end
    end
    assign in_ready  = ~fv | mid_ready;
    assign mid_valid = fv;
    assign mid_data  = fd;
    assign f_occ     = fv;
  end else begin : g_nofwd
    assign in_ready  = mid_ready;
    assign mid_valid = in_valid;
    assign mid_data  = in_data;
    assign f_occ     = 1'b0;
  end

  if (HAS_BWD) begin : g_bwd
    logic          sv;
    logic [DW-1:0] sd;
    // Skid fills only when a beat is accepted but cannot leave; while full,
    // upstream ready is low so fill and drain never coincide.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sv <= 1'b0;
        sd <= '0;
      end else if (sv && out_ready) begin
        sv <= 1'b0;
      end else if (mid_valid && !sv && !out_ready) begin
        sv <= 1'b1;
        sd <= mid_data;
      end
    end
    assign mid_ready = ~sv;
    assign out_valid = mid_valid | sv;
    assign out_data  = sv ? sd : mid_data;
    assign b_occ     = sv;
  end else begin : g_nobwd
    assign mid_ready = out_ready;
    assign out_valid = mid_valid;
    assign out_data  = mid_data;
    assign b_occ     = 1'b0;
  end

  assign occ = {1'b0, f_occ} + {1'b0, b_occ};
endmodule

module axi_rs_chain #(
  parameter int DW     = 64,
  parameter int STAGES = 1,
  parameter int MODE   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] m_data,
  input  logic          m_valid,
  output logic          m_ready,
  output logic [DW-1:0] s_data,
  output logic          s_valid,
  input  logic          s_ready,
  output logic [4:0]    occ,
  output logic          idle
);
  if (MODE == 0) begin : g_pass
    assign s_data  = m_data;
    assign s_valid = m_valid;
    assign m_ready = s_ready;
    assign occ     = 5'd0;
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
  end else begin : g_chain
    logic [STAGES-1:0][1:0] st_occ;
    logic [4:0]             occ_sum;

    // Per-stage link signals live in each generate block so the valid and
    // ready chains are separate nets rather than one self-referencing vector.
    for (genvar i = 0; i < STAGES; i++) begin : g_st
      logic [DW-1:0] id, od;
      logic          iv, ir, ov, orr;
      logic [1:0]    so;
      if (i == 0) begin : g_head
        assign id = m_data;
        assign iv = m_valid;
      end else begin : g_link
        assign id = g_st[i-1].od;
        assign iv = g_st[i-1].ov;
      end
      if (i == STAGES-1) begin : g_tail
        assign orr = s_ready;
      end else begin : g_next
        assign orr = g_st[i+1].ir;
      end
      axi_rs_stage #(.DW(DW), .MODE(MODE)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .in_data  (id),
        .in_valid (iv),
        .in_ready (ir),
        .out_data (od),
        .out_valid(ov),
        .out_ready(orr),
        .occ      (so)
      );
      assign st_occ[i] = so;
    end

    assign m_ready = g_st[0].ir;
    assign s_data  = g_st[STAGES-1].od;
    assign s_valid = g_st[STAGES-1].ov;

    always_comb begin
      occ_sum = '0;
      for (int i = 0; i < STAGES; i++) occ_sum = occ_sum + 5'(st_occ[i]);
    end
    assign occ = occ_sum;
  end

  assign idle = (occ == 5'd0) & ~m_valid;
endmodule

// File: tb/tb_axi_rs_chain.sv
module tb_axi_rs_chain;
  localparam int DW = 16;
  localparam int N  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] md [N];
  logic [DW-1:0] sd [N];
  logic [DW-1:0] held [N];
  logic          mv [N];
  logic          mr [N];
  logic          sv [N];
  logic          sr [N];
  logic          idl [N];
  logic          stall [N];
  logic [4:0]    oc [N];
  logic [4:0]    omax [N];
  logic [DW-1:0] sbq [N][$];
  int            rcvd [N];
  int            n_tests = 0;
  int            n_fail  = 0;

  // 0: full x2, 1: full x1, 2: backward x1, 3: forward x3, 4: full x4, 5: pass
  axi_rs_chain #(.DW(DW), .STAGES(2), .MODE(3)) u_m3s2 (.clk(clk), .rst(rst),
    .m_data(md[0]), .m_valid(mv[0]), .m_ready(mr[0]), .s_data(sd[0]), .s_valid(sv[0]),
    .s_ready(sr[0]), .occ(oc[0]), .idle(idl[0]));
  axi_rs_chain #(.DW(DW), .STAGES(1), .MODE(3)) u_m3s1 (.clk(clk), .rst(rst),
    .m_data(md[1]), .m_valid(mv[1]), .m_ready(mr[1]), .s_data(sd[1]), .s_valid(sv[1]),
    .s_ready(sr[1]), .occ(oc[1]), .idle(idl[1]));
  axi_rs_chain #(.DW(DW), .STAGES(1), .MODE(2)) u_m2s1 (.clk(clk), .rst(rst),
    .m_data(md[2]), .m_valid(mv[2]), .m_ready(mr[2]), .s_data(sd[2]), .s_valid(sv[2]),
    .s_ready(sr[2]), .occ(oc[2]), .idle(idl[2]));
  axi_rs_chain #(.DW(DW), .STAGES(3), .MODE(1)) u_m1s3 (.clk(clk), .rst(rst),
    .m_data(md[3]), .m_valid(mv[3]), .m_ready(mr[3]), .s_data(sd[3]), .s_valid(sv[3]),
    .s_ready(sr[3]), .occ(oc[3]), .idle(idl[3]));
  axi_rs_chain #(.DW(DW), .STAGES(4), .MODE(3)) u_m3s4 (.clk(clk), .rst(rst),
    .m_data(md[4]), .m_valid(mv[4]), .m_ready(mr[4]), .s_data(sd[4]), .s_valid(sv[4]),
    .s_ready(sr[4]), .occ(oc[4]), .idle(idl[4]));
  axi_rs_chain #(.DW(DW), .STAGES(1), .MODE(0)) u_m0 (.clk(clk), .rst(rst),
    .m_data(md[5]), .m_valid(mv[5]), .m_ready(mr[5]), .s_data(sd[5]), .s_valid(sv[5]),
    .s_ready(sr[5]), .occ(oc[5]), .idle(idl[5]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted upstream beats are pushed, downstream beats popped
  // and compared in order. Reset discards everything held.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        sbq[i].delete();
        stall[i] = 1'b0;
      end else begin
        if (mv[i] && mr[i]) sbq[i].push_back(md[i]);
        if (sv[i] && sr[i]) begin
          rcvd[i]++;
          if (sbq[i].size() == 0) chk($sformatf("sb%0d_unexpected_beat", i), 1, 0);
          else chk($sformatf("sb%0d_data", i), 32'(sd[i]), 32'(sbq[i].pop_front()));
        end
        if (stall[i] && i != 5) chk($sformatf("hold%0d_s_data", i), 32'(sd[i]), 32'(held[i]));
        stall[i] = sv[i] && !sr[i];
        held[i]  = sd[i];
        if (oc[i] > omax[i]) omax[i] = oc[i];
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  logic [DW-1:0] v30 [3];
  logic [DW-1:0] v35d [5];
  logic          v35v [5];
  logic          v35r [5];
  logic          skid_m, acc, got;
  int            n32, n33, n34, cyc;

  initial begin
    v30  = '{16'h0011, 16'h0022, 16'h0033};
    v35d = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hFFFF, 16'h5555};
    v35v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    v35r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < N; i++) begin
      md[i] = '0; mv[i] = 1'b0; sr[i] = 1'b0;
      rcvd[i] = 0; omax[i] = '0; stall[i] = 1'b0; held[i] = '0;
    end

    // Reset state
    rst = 1'b1;
    mv[2] = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst_m3s2_s_valid", sv[0], 0);
    chk("rst_m3s2_m_ready", mr[0], 1);
    chk("rst_m3s2_occ", oc[0], 0);
    chk("rst_m3s2_idle", idl[0], 1);
    chk("rst_m3s1_s_valid", sv[1], 0);
    chk("rst_m2_s_valid_follows", sv[2], 1);
    chk("rst_m2_m_ready", mr[2], 1);
    chk("rst_m1_m_ready", mr[3], 1);
    chk("rst_m3s4_occ", oc[4], 0);
    mv[2] = 1'b0;
    step;
    rst = 1'b0;
    step;

    // Full x2: three back-to-back beats, output two edges after presentation
    sr[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin mv[0] = 1'b1; md[0] = v30[k]; end
      else mv[0] = 1'b0;
      @(negedge clk);
      chk("r030_s_valid", sv[0], (k >= 2 && k <= 4));
      if (k >= 2 && k <= 4) chk("r030_s_data", 32'(sd[0]), 32'(v30[k-2]));
      if (k < 3) chk("r030_m_ready", mr[0], 1);
      step;
    end

    // Full x1 with downstream blocked: capacity 2, then drain in order
    mv[1] = 1'b1; md[1] = 16'h000A;
    @(negedge clk); chk("r031_ready_a", mr[1], 1); step;
    md[1] = 16'h000B;
    @(negedge clk); chk("r031_ready_b", mr[1], 1); chk("r031_occ1", oc[1], 1); step;
    md[1] = 16'h000C;
    @(negedge clk);
    chk("r031_ready_full", mr[1], 0); chk("r031_occ2", oc[1], 2);
    chk("r031_s_data_a", sd[1], 16'h000A); chk("r031_idle", idl[1], 0);
    step;
    md[1] = 16'h00FF;
    @(negedge clk); chk("r031_held_occ", oc[1], 2); chk("r031_held_data", sd[1], 16'h000A); step;
    md[1] = 16'h000C; sr[1] = 1'b1;
    @(negedge clk); chk("r031_drain_a", sd[1], 16'h000A); step;
    @(negedge clk); chk("r031_drain_b", sd[1], 16'h000B); chk("r031_ready_again", mr[1], 1); step;
    mv[1] = 1'b0;
    @(negedge clk); chk("r031_drain_c", sd[1], 16'h000C); chk("r031_occ_c", oc[1], 1); step;
    @(negedge clk); chk("r031_empty_valid", sv[1], 0); chk("r031_empty_occ", oc[1], 0); step;

    // Backward x1, ready toggling under continuous input
    sr[2] = 1'b1; mv[2] = 1'b1; md[2] = 16'h0100; skid_m = 1'b0; n32 = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("r032_m_ready", mr[2], !skid_m);
      acc = !skid_m;
      skid_m = skid_m ? !sr[2] : (mv[2] && !sr[2]);
      step;
      if (acc) begin md[2] = md[2] + 16'h1; n32++; end
      sr[2] = !sr[2];
    end
    mv[2] = 1'b0; sr[2] = 1'b1;
    repeat (3) step;
    chk("r032_count", rcvd[2], n32);

    // Forward x3, random valid/ready
    n33 = 0; cyc = 0;
    while (n33 < 10000 && cyc < 60000) begin
      mv[3] = 1'($urandom_range(0, 1));
      sr[3] = 1'($urandom_range(0, 1));
      md[3] = DW'(n33);
      @(negedge clk);
      if (mv[3] && mr[3]) n33++;
      step;
      cyc++;
    end
    chk("r033_sent", n33, 10000);
    mv[3] = 1'b0; sr[3] = 1'b1;
    repeat (8) step;
    chk("r033_rcvd", rcvd[3], 10000);
    chk("r033_occ_le_3", (omax[3] <= 5'd3), 1);

    for (int i = 0; i < 4; i++) chk($sformatf("sb%0d_empty", i), sbq[i].size(), 0);

    // Full x4: fill, reset mid-stream, first beat after release comes out first
    sr[4] = 1'b0; n34 = 0;
    for (int k = 0; k < 20; k++) begin
      mv[4] = 1'b1; md[4] = 16'h0040 + DW'(n34);
      @(negedge clk);
      if (mr[4]) n34++;
      step;
    end
    chk("r034_accepted", n34, 8);
    chk("r034_occ_full", oc[4], 8);
    chk("r034_m_ready_full", mr[4], 0);
    rst = 1'b1;
    #1;
    chk("r034_rst_s_valid", sv[4], 0);
    chk("r034_rst_occ", oc[4], 0);
    chk("r034_rst_m_ready", mr[4], 1);
    mv[4] = 1'b0;
    step;
    rst = 1'b0; md[4] = 16'h005A; mv[4] = 1'b1; sr[4] = 1'b1;
    @(negedge clk); chk("r034_accept_5a", mr[4], 1); step;
    mv[4] = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sv[4]) begin got = 1'b1; break; end
    end
    chk("r034_out_seen", got, 1);
    chk("r034_first_out", sd[4], 16'h005A);
    step;

    // Pass-through
    for (int k = 0; k < 5; k++) begin
      md[5] = v35d[k]; mv[5] = v35v[k]; sr[5] = v35r[k];
      #1;
      chk("r035_s_data", sd[5], v35d[k]);
      chk("r035_s_valid", sv[5], v35v[k]);
      chk("r035_m_ready", mr[5], v35r[k]);
      chk("r035_occ", oc[5], 0);
      step;
    end
    mv[5] = 1'b0;
    repeat (2) step;
    chk("sb4_empty", sbq[4].size(), 0);
    chk("sb5_empty", sbq[5].size(), 0);
    chk("r035_beats", rcvd[5], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_rs_chain.md
AXI_RS_CHAIN -- requirements
Module: axi_rs_chain

Interface
REQ-001 The module SHALL have parameter DW, default 64, meaning the payload width in bits (legal range 1..1024).
REQ-002 The module SHALL have parameter STAGES, default 1, meaning the number of cascaded slice stages (legal range 1..8).
REQ-003 The module SHALL have parameter MODE, default 3, meaning the per-stage slice type: 0 = pass, 1 = forward, 2 = backward, 3 = full.
REQ-004 The module SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, width 1: asynchronous active-high reset.
REQ-006 The module SHALL have port m_data, input, width DW: upstream payload.
REQ-007 The module SHALL have port m_valid, input, width 1: upstream valid.
REQ-008 The module SHALL have port m_ready, output, width 1: upstream ready.
REQ-009 The module SHALL have port s_data, output, width DW: downstream payload.
REQ-010 The module SHALL have port s_valid, output, width 1: downstream valid.
REQ-011 The module SHALL have port s_ready, input, width 1: downstream ready.
REQ-012 The module SHALL have port occ, output, width 5: count of beats currently held in registers.
REQ-013 The module SHALL have port idle, output, width 1: high when occ == 0 and m_valid == 0.

Function
REQ-014 A beat SHALL transfer on an edge where valid and ready are both high, at the m side and at the s side independently.
REQ-015 MODE 0 SHALL connect s_data = m_data, s_valid = m_valid and m_ready = s_ready combinationally, with occ fixed at 0 and STAGES ignored.
REQ-016 Forward stage: a 1-entry output register; its out-valid/data are registered; its in-ready = ~out_valid | out_ready; latency 1 edge; capacity 1.
REQ-017 Backward stage: a 1-entry skid register; in-ready = ~skid_valid (registered); out_valid = in_valid | skid_valid; out_data = skid_valid ? skid_data : in_data.
REQ-018 A backward stage SHALL capture into the skid register when in_valid & in_ready & ~out_ready; it SHALL clear the skid register when skid_valid & out_ready.
REQ-019 Full stage: a forward stage feeding a backward stage; latency 1 edge; capacity 2; no combinational path from s_ready to m_ready or from m_valid to s_valid.
REQ-020 The chain SHALL cascade STAGES identical stages of type MODE; a beat's minimum latency SHALL be STAGES edges for MODE 1/3 and 0 for MODE 2.
REQ-021 With s_ready held high and m_valid held high, throughput SHALL be one beat per cycle in every MODE after the pipeline fills.
REQ-022 Ordering SHALL be strict FIFO; no beat SHALL be dropped or duplicated under any valid/ready pattern.
REQ-023 occ SHALL equal the sum of valid forward-registers and valid skid-registers, updated each edge; maximum is STAGES*2 (MODE 3) or STAGES (MODE 1/2).
REQ-024 When the chain is full and s_ready is low, m_ready SHALL be low; m_data/m_valid changes SHALL not alter held beats.
REQ-025 A simultaneous push and pop in a full stage SHALL keep its occupancy constant and pass the data through with no bubble.
REQ-026 s_data SHALL be held stable while s_valid is high and s_ready is low.

Reset
REQ-027 While rst is high, all valid and skid-valid registers SHALL be 0 and all data registers 0, regardless of clk.
REQ-028 During and after reset, the outputs SHALL be: s_valid = 0 (MODE 1/3) or s_valid = m_valid (MODE 0/2); m_ready = 1 (MODE 1/2/3); occ = 0.
REQ-029 Reset asserted mid-transfer SHALL discard all held beats immediately; the first beat accepted after release SHALL be the first beat emitted.

Verification
REQ-030 MODE 3, STAGES 2, s_ready = 1, send 0x11, 0x22, 0x33 back-to-back -> s_data emits 0x11, 0x22, 0x33 on consecutive cycles starting 2 edges after the first accept.
REQ-031 MODE 3, STAGES 1, s_ready = 0, push 3 beats -> m_ready drops after 2 accepts, occ = 2; raise s_ready -> 0xA, 0xB drain in order, then the third beat follows.
REQ-032 MODE 2, STAGES 1, s_ready toggles 1/0 every cycle with continuous input -> no loss or duplication; m_ready falls exactly one edge after a capture into the skid register.
REQ-033 MODE 1, STAGES 3, random valid/ready at 50% each for 10000 beats -> scoreboard order matches, and occ never exceeds 3.
REQ-034 MODE 3, STAGES 4, fill to occ = 8, assert rst for 1 cycle -> s_valid = 0 and occ = 0 immediately; the next input 0x5A is the first output.
REQ-035 MODE 0 -> s_valid, s_data and m_ready follow the inputs in the same cycle, and occ stays 0.
